// File: rtl/scalar_wb_pkg.sv
// Shared types for the scalar writeback arbiter: request payload and
// the source tag carried alongside the registered register-file write.
package scalar_wb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REG_AW   = 5;

  typedef struct packed {
    logic [REG_AW-1:0]   rd;
    logic [XLEN_DEF-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LSU
  } wb_src_e;

endpackage

// File: rtl/scalar_wb_arbiter_wb_fifo.sv
// Synchronous FIFO buffering LSU load returns until they win the write port.
// Power-of-two depth so the pointers wrap naturally.
module wb_fifo
  import scalar_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_req_t                push_data,
  input  logic                   pop,
  output wb_req_t                head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which
  // entries are valid, so flushing them is enough and keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/scalar_wb_arbiter.sv
// Writeback arbiter for the scalar register file: merges ALU results and
// buffered load returns into one registered write, and tracks pending loads.
module scalar_wb_arbiter
  import scalar_wb_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int LSU_FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alu_valid,
  input  logic [REG_AW-1:0]               alu_rd,
  input  logic [XLEN-1:0]                 alu_data,
  output logic                            alu_ready,
  input  logic                            lsu_valid,
  input  logic [REG_AW-1:0]               lsu_rd,
  input  logic [XLEN-1:0]                 lsu_data,
  output logic                            lsu_ready,
  input  logic                            issue_valid,
  input  logic [REG_AW-1:0]               issue_rd,
  output logic                            rf_we,
  output logic [REG_AW-1:0]               rf_waddr,
  output logic [XLEN-1:0]                 rf_wdata,
  output logic [31:0]                     pending,
  output logic [$clog2(LSU_FIFO_DEPTH):0] fifo_count
);

  wb_req_t fifo_head;
  wb_req_t win;
  logic    fifo_full;
  logic    fifo_empty;
  logic    sel_alu;
  logic    sel_lsu;
  logic    win_valid;
  wb_src_e wb_src;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  wb_fifo #(.DEPTH(LSU_FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (lsu_valid && lsu_ready),
    .push_data ('{rd: lsu_rd, data: lsu_data}),
    .pop       (sel_lsu),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A full buffer takes priority so loads cannot be starved indefinitely.
  assign alu_ready = !fifo_full;
  assign lsu_ready = !fifo_full;
  assign sel_lsu   = fifo_full || (!alu_valid && !fifo_empty);
  assign sel_alu   = !fifo_full && alu_valid;
  assign win_valid = sel_alu || sel_lsu;

  // NOTE: every always_comb output gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    win      = '{rd: alu_rd, data: alu_data};
    set_mask = '0;
    clr_mask = '0;
    if (sel_lsu) win = fifo_head;
    if (issue_valid && issue_rd != '0) set_mask[issue_rd] = 1'b1;
    if (rf_we && wb_src == WB_LSU) clr_mask[rf_waddr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wb_src   <= WB_NONE;
      pending  <= '0;
    end else begin
      rf_we <= win_valid && win.rd != '0;
      if (win_valid) begin
        rf_waddr <= win.rd;
        rf_wdata <= win.data;
      end
      if (!win_valid || win.rd == '0) wb_src <= WB_NONE;
      else if (sel_lsu)               wb_src <= WB_LSU;
      else                            wb_src <= WB_ALU;
      // Set is applied after clear so a re-issue on the clear edge wins.
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Directed bench for scalar_wb_arbiter: expected writes go into a queue,
// a monitor pops and compares on every rf_we cycle.
module tb_scalar_wb_arbiter;
  import scalar_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, issue_valid;
  logic [4:0]  alu_rd, lsu_rd, issue_rd;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending;
  logic [2:0]  fifo_count;

  int tests = 0;
  int fails = 0;
  wb_req_t exp_q[$];
  logic    last_alu_ready, last_lsu_ready;

  scalar_wb_arbiter #(.XLEN(32), .LSU_FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending(pending), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back('{rd: rd, data: data});
  endtask

  // One cycle of stimulus, starting and ending 1 time unit after a rising edge.
  task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                     input logic iv, input logic [4:0] ird);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    issue_valid = iv; issue_rd = ird;
    #1;
    last_alu_ready = alu_ready;
    last_lsu_ready = lsu_ready;
    @(posedge clk); #1;
    alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every write the DUT presents must match the next expected one.
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'd0, rf_waddr}, 32'hFFFF_FFFF);
      end else begin
        wb_req_t e;
        e = exp_q.pop_front();
        check("wr_addr", {27'd0, rf_waddr}, {27'd0, e.rd});
        check("wr_data", rf_wdata, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0;
    rst = 1'b1;
    #23 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check("rst_we", {31'd0, rf_we}, 0);
    check("rst_waddr", {27'd0, rf_waddr}, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_pending", pending, 0);
    check("rst_count", {29'd0, fifo_count}, 0);
    check("rst_alu_ready", {31'd0, alu_ready}, 1);
    check("rst_lsu_ready", {31'd0, lsu_ready}, 1);

    // ALU only
    expect_wr(5, 32'hDEADBEEF);
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    check("alu_we_c1", {31'd0, rf_we}, 1);
    idle();
    check("alu_we_c2", {31'd0, rf_we}, 0);

    // Collision: ALU wins, load follows next cycle
    expect_wr(3, 32'h11);
    expect_wr(4, 32'h22);
    cyc(1, 3, 32'h11, 1, 4, 32'h22, 0, 0);
    check("coll_count_c1", {29'd0, fifo_count}, 1);
    check("coll_addr_c1", {27'd0, rf_waddr}, 3);
    idle();
    check("coll_count_c2", {29'd0, fifo_count}, 0);
    check("coll_addr_c2", {27'd0, rf_waddr}, 4);
    idle();
    check("coll_we_c3", {31'd0, rf_we}, 0);

    // Backpressure: continuous ALU while four loads fill the buffer
    for (int i = 0; i < 4; i++) expect_wr(5'(20 + i), 32'h100 + 32'(20 + i));
    expect_wr(8, 32'h208);
    expect_wr(24, 32'h118);
    for (int i = 9; i < 12; i++) expect_wr(5'(i), 32'h200 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      cyc(1, 5'(20 + i), 32'h100 + 32'(20 + i), 1, 5'(8 + i), 32'h200 + 32'(8 + i), 0, 0);
      check("bp_alu_accept", {31'd0, last_alu_ready}, 1);
    end
    check("bp_count_full", {29'd0, fifo_count}, 4);
    cyc(1, 24, 32'h118, 0, 0, 0, 0, 0);
    check("bp_alu_ready_full", {31'd0, last_alu_ready}, 0);
    check("bp_lsu_ready_full", {31'd0, last_lsu_ready}, 0);
    check("bp_count_after_pop", {29'd0, fifo_count}, 3);
    cyc(1, 24, 32'h118, 0, 0, 0, 0, 0);
    check("bp_alu_retry", {31'd0, last_alu_ready}, 1);
    repeat (4) idle();
    check("bp_drained", {29'd0, fifo_count}, 0);

    // Scoreboard: set, clear one cycle after the write, set wins on clear edge
    cyc(0, 0, 0, 0, 0, 0, 1, 7);
    check("sb_set7", pending, 32'h80);
    expect_wr(7, 32'h77);
    cyc(0, 0, 0, 1, 7, 32'h77, 0, 0);
    idle();
    check("sb_we_load7", {31'd0, rf_we}, 1);
    check("sb_pend7_during_we", pending, 32'h80);
    cyc(0, 0, 0, 0, 0, 0, 1, 7);
    check("sb_set_wins", pending, 32'h80);
    expect_wr(7, 32'h700);
    cyc(1, 7, 32'h700, 0, 0, 0, 1, 6);
    idle();
    check("sb_alu_no_clear", pending, 32'hC0);
    expect_wr(6, 32'h66);
    expect_wr(7, 32'h78);
    cyc(0, 0, 0, 1, 6, 32'h66, 0, 0);
    cyc(0, 0, 0, 1, 7, 32'h78, 0, 0);
    idle();
    check("sb_clear6", pending, 32'h80);
    idle();
    check("sb_clear7", pending, 32'h0);

    // Register 0: consumed, never written, never pending
    cyc(1, 0, 32'hAAAA, 1, 0, 32'hBBBB, 1, 0);
    check("r0_we_c1", {31'd0, rf_we}, 0);
    check("r0_count_c1", {29'd0, fifo_count}, 1);
    idle();
    check("r0_we_c2", {31'd0, rf_we}, 0);
    check("r0_count_c2", {29'd0, fifo_count}, 0);
    check("r0_pending", pending, 0);

    // Reset mid-operation with three buffered loads and pending[9]
    for (int i = 0; i < 3; i++) begin
      expect_wr(5'(12 + i), 32'h300 + 32'(i));
      cyc(1, 5'(12 + i), 32'h300 + 32'(i), 1, 5'(16 + i), 32'h400 + 32'(i), i == 0, 9);
    end
    check("mid_count", {29'd0, fifo_count}, 3);
    check("mid_pending", pending, 32'h200);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_we", {31'd0, rf_we}, 0);
    check("arst_count", {29'd0, fifo_count}, 0);
    check("arst_pending", pending, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    repeat (4) begin
      idle();
      check("post_rst_no_we", {31'd0, rf_we}, 0);
    end
    check("post_rst_count", {29'd0, fifo_count}, 0);
    check("exp_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
